alu_seq_param: RTL and testbench
================================

// Module: alu_seq_param
// PURPOSE
//  Registered, parametrised successor to the 6-bit combinational ALU. Same 8-op set and ZF/PF/OF flags, any width W.
//  Adds valid/ready handshakes on input and output, and an iterative W-cycle multiplier instead of a combinational array.
//  Sits between an operand source (register file/FSM) and a result consumer; one operation in flight at a time.
// PARAMETERS
//  W        6   operand/result width (two's complement), W >= 3
//  CNT_W    $clog2(W)+1   multiplier iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    operands + sel valid this cycle
//  in_ready   out  1    block can accept an operation
//  sel        in   3    opcode (below)
//  a, b       in   W    signed operands
//  out_valid  out  1    y/zf/pf/of hold a valid result
//  out_ready  in   1    consumer takes result this cycle
//  y          out  W    signed result
//  zf, pf, of out  1    zero, parity, overflow flags for y
// BEHAVIOUR
//  Opcodes: 0 XOR, 1 AND, 2 OR, 3 A>>>1 (arith shift), 4 A+B, 5 A*B, 6 A-B, 7 A*5. B ignored for 3 and 7.
//  Arithmetic: full-precision signed result computed; y = low W bits.
//   of = 1 when full result is not representable in W signed bits (add/sub/mul/mul5), else 0; ops 0-3 force of=0.
//  zf = (y==0). pf = ~^y (1 when y has an even number of ones, incl. y==0).
//  FSM: IDLE, MUL_RUN, DONE.
//   IDLE: in_ready=1, out_valid=0. in_valid&in_ready at edge k latches sel,a,b.
//    sel!=5 -> result/flags registered at edge k, state DONE (latency 1: out_valid high cycle after accept).
//    sel==5 -> state MUL_RUN, counter=0, accumulator=0.
//   MUL_RUN: in_ready=0, out_valid=0; one shift-add step per cycle on |a|,|b|; sign fixed at end.
//    After W steps (edge k+W) y/flags load, state DONE. Accept-to-out_valid latency = W cycles.
//   DONE: out_valid=1; y/zf/pf/of stable while out_valid&~out_ready.
//    out_ready=1: result consumed at that edge.
//    in_ready = out_ready in DONE (back-to-back): if in_valid also 1, new op accepted same edge
//    (sel!=5 -> stay DONE with new result; sel==5 -> MUL_RUN); else -> IDLE.
//  Inputs a,b,sel are don't-care except at the accept edge; changes during MUL_RUN have no effect.
//  Reset (any time, incl. mid-MUL_RUN): state IDLE, y=0, zf=0, pf=0, of=0, out_valid=0, in_ready=1 after release,
//   counter/accumulator cleared; in-flight op discarded, no result emitted.
//  Edge values: mul of most-negative by itself (W=6: -32*-32=1024) -> y=0, of=1; zf=1 in this case too.
//  Shift of most-negative: -32>>>1 = -16, of=0.
//  No simultaneous-output hazard: only one op in flight, y never changes while out_valid&~out_ready.
// TESTING (W=6)
//  1 Reset: assert rst_n=0 mid-cycle -> out_valid=0,y=0,flags=0 immediately; after release in_ready=1.
//  2 ADD a=31,b=1 accepted edge k -> edge k+1 out_valid=1, y=6'b100000 (-32), of=1, zf=0, pf=0.
//  3 SUB a=5,b=5 -> y=0, zf=1, pf=1, of=0; shift a=-6 -> y=-3 (6'b111101), of=0, pf=0.
//  4 MUL a=-3,b=7 -> in_ready=0 for cycles k+1..k+5, out_valid first high after edge k+6, y=-21 (6'b101011), of=0;
//    MUL a=-32,b=-32 -> y=0, zf=1, of=1.
//  5 MUL5 a=7 -> y=6'b100011 (-29), of=1; back-to-back: out_ready=1,in_valid=1 in DONE -> next op accepted, no bubble.
//  6 Backpressure: out_ready=0 for 5 cycles -> y/flags/out_valid held, in_ready=0, in_valid ignored;
//    rst_n pulse during MUL_RUN -> no result ever appears for that op, next op runs normally.

Source files
------------

// File: rtl/alu_seq_param.sv
// alu_seq_param
//   Registered, parametrised ALU with valid/ready handshakes on both sides.
//   Eight operations (XOR, AND, OR, arithmetic shift right, add, multiply,
//   subtract, multiply-by-5) on W-bit two's complement operands, with zero,
//   parity and overflow flags. Multiply is iterative: one shift-add step per
//   cycle on operand magnitudes, sign applied on the final step. Only one
//   operation is in flight at a time.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  sel/a/b valid this cycle
//   in_ready   out  1  block accepts an operation this cycle
//   sel        in   3  opcode
//   a, b       in   W  signed operands
//   out_valid  out  1  y/zf/pf/of hold a valid result
//   out_ready  in   1  consumer takes the result this cycle
//   y          out  W  signed result (low W bits of the full-precision value)
//   zf, pf, of out  1  zero, even-parity, signed-overflow flags for y
module alu_seq_param #(
  parameter  int W     = 6,
  localparam int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         zf,
  output logic         pf,
  output logic         of
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_XOR  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_SAR  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_MUL5 = 3'd7;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);
  // 2^(W-1): largest magnitude a negative W-bit result may have.
  localparam logic [2*W-1:0] HALF_RANGE = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

  // Magnitude of a two's complement value; most-negative maps to 2^(W-1).
  function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
    if (v[W-1]) begin
      return ~v + {{(W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Even-parity flag: 1 when v has an even number of ones.
  function automatic logic even_parity(input logic [W-1:0] v);
    return ~(^v);
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2*W-1:0]   acc_r;
  logic [2*W-1:0]   mcand_r;
  logic [W-1:0]     mplier_r;
  logic             neg_r;

  logic             accept_s;
  logic             start_mul_s;
  logic             load_alu_s;
  logic             load_mul_s;

  logic [W:0]       add_s;
  logic [W:0]       sub_s;
  logic [W+2:0]     a_ext_s;
  logic [W+2:0]     mul5_s;
  logic [W-1:0]     alu_y_s;
  logic             alu_of_s;

  logic [2*W-1:0]   addend_s;
  logic [2*W-1:0]   acc_nxt_s;
  logic [2*W-1:0]   prod_neg_s;
  logic [W-1:0]     mul_y_s;
  logic             mul_of_s;

  // Input handshake: ready when idle, or when the held result leaves this cycle.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      ST_IDLE: in_ready = 1'b1;
      ST_MUL:  in_ready = 1'b0;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept_s = in_valid & in_ready;

  // Single-cycle operations with their overflow conditions.
  always_comb begin
    add_s    = {a[W-1], a} + {b[W-1], b};
    sub_s    = {a[W-1], a} - {b[W-1], b};
    a_ext_s  = {{3{a[W-1]}}, a};
    mul5_s   = (a_ext_s << 2) + a_ext_s;
    alu_y_s  = {W{1'b0}};
    alu_of_s = 1'b0;
    case (sel)
      OP_XOR: begin
        alu_y_s  = a ^ b;
        alu_of_s = 1'b0;
      end
      OP_AND: begin
        alu_y_s  = a & b;
        alu_of_s = 1'b0;
      end
      OP_OR: begin
        alu_y_s  = a | b;
        alu_of_s = 1'b0;
      end
      OP_SAR: begin
        alu_y_s  = {a[W-1], a[W-1:1]};
        alu_of_s = 1'b0;
      end
      OP_ADD: begin
        alu_y_s  = add_s[W-1:0];
        alu_of_s = add_s[W] ^ add_s[W-1];
      end
      OP_SUB: begin
        alu_y_s  = sub_s[W-1:0];
        alu_of_s = sub_s[W] ^ sub_s[W-1];
      end
      OP_MUL5: begin
        // Representable only if the top four bits are all sign copies.
        alu_y_s  = mul5_s[W-1:0];
        alu_of_s = ~((&mul5_s[W+2:W-1]) | ~(|mul5_s[W+2:W-1]));
      end
      default: begin
        alu_y_s  = {W{1'b0}};
        alu_of_s = 1'b0;
      end
    endcase
  end

  // Multiplier step and final signed result, folded so the last step loads y.
  always_comb begin
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {(2*W){1'b0}};
    end
    acc_nxt_s  = acc_r + addend_s;
    prod_neg_s = ~acc_nxt_s + {{(2*W-1){1'b0}}, 1'b1};
    if (neg_r) begin
      mul_y_s  = prod_neg_s[W-1:0];
      mul_of_s = (acc_nxt_s > HALF_RANGE);
    end else begin
      mul_y_s  = acc_nxt_s[W-1:0];
      mul_of_s = (acc_nxt_s >= HALF_RANGE);
    end
  end

  // Next-state decode and load strobes for the result registers.
  always_comb begin
    state_nxt_s = state_r;
    start_mul_s = 1'b0;
    load_alu_s  = 1'b0;
    load_mul_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (sel == OP_MUL) begin
            state_nxt_s = ST_MUL;
            start_mul_s = 1'b1;
          end else begin
            state_nxt_s = ST_DONE;
            load_alu_s  = 1'b1;
          end
        end else if ((state_r == ST_DONE) && out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_MUL: begin
        if (cnt_r == LAST_STEP) begin
          state_nxt_s = ST_DONE;
          load_mul_s  = 1'b1;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and shift-add multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      mcand_r  <= {(2*W){1'b0}};
      mplier_r <= {W{1'b0}};
      neg_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (start_mul_s) begin
        cnt_r    <= {CNT_W{1'b0}};
        acc_r    <= {(2*W){1'b0}};
        mcand_r  <= {{W{1'b0}}, abs_w(a)};
        mplier_r <= abs_w(b);
        neg_r    <= a[W-1] ^ b[W-1];
      end else if (state_r == ST_MUL) begin
        cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        acc_r    <= acc_nxt_s;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
      end else begin
        cnt_r    <= cnt_r;
        acc_r    <= acc_r;
        mcand_r  <= mcand_r;
        mplier_r <= mplier_r;
      end
    end
  end

  // Result and flag registers; held unchanged until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= {W{1'b0}};
      zf        <= 1'b0;
      pf        <= 1'b0;
      of        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_nxt_s == ST_DONE);
      if (load_alu_s) begin
        y  <= alu_y_s;
        zf <= (alu_y_s == {W{1'b0}});
        pf <= even_parity(alu_y_s);
        of <= alu_of_s;
      end else if (load_mul_s) begin
        y  <= mul_y_s;
        zf <= (mul_y_s == {W{1'b0}});
        pf <= even_parity(mul_y_s);
        of <= mul_of_s;
      end else begin
        y  <= y;
        zf <= zf;
        pf <= pf;
        of <= of;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param at W=6: table of hand-computed vectors, a small
// integer reference model for random operations, and hand-written sequences
// for latency, back-to-back, backpressure and reset corner cases.
module tb_alu_seq_param;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         zf;
  logic         pf;
  logic         of;

  alu_seq_param #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zf(zf), .pf(pf), .of(of)
  );

  typedef struct {
    logic [W-1:0] y;
    logic         zf;
    logic         pf;
    logic         of;
  } exp_t;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         zf;
    logic         pf;
    logic         of;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: full-precision integer arithmetic, then truncate and flag.
  function automatic exp_t model(input logic [2:0] s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    int ai, bi, f;
    bit arith;
    logic [W-1:0] yy;
    ai = int'($signed(aa));
    bi = int'($signed(bb));
    f = 0;
    arith = 1'b1;
    case (s)
      3'd0: begin yy = aa ^ bb; arith = 1'b0; end
      3'd1: begin yy = aa & bb; arith = 1'b0; end
      3'd2: begin yy = aa | bb; arith = 1'b0; end
      3'd3: begin f = ai >>> 1; yy = f[W-1:0]; arith = 1'b0; end
      3'd4: begin f = ai + bi; yy = f[W-1:0]; end
      3'd5: begin f = ai * bi; yy = f[W-1:0]; end
      3'd6: begin f = ai - bi; yy = f[W-1:0]; end
      default: begin f = ai * 5; yy = f[W-1:0]; end
    endcase
    e.y  = yy;
    e.zf = (yy == '0);
    e.pf = ~(^yy);
    e.of = arith && ((f < -(1 << (W-1))) || (f > (1 << (W-1)) - 1));
    return e;
  endfunction

  // Scoreboard check whenever a result is handed over.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("y",  32'(y),  32'(mon_e.y));
        chk("zf", 32'(zf), 32'(mon_e.zf));
        chk("pf", 32'(pf), 32'(mon_e.pf));
        chk("of", 32'(of), 32'(mon_e.of));
      end
    end
  end

  task automatic send(input logic [2:0] s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input exp_t e, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    @(negedge clk);
    sel = s; a = aa; b = bb; in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (in_ready) begin
        q.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      in_valid = 1'b0;
      chk("send_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  function automatic exp_t vexp(input vec_t v);
    exp_t e;
    e.y = v.y; e.zf = v.zf; e.pf = v.pf; e.of = v.of;
    return e;
  endfunction

  vec_t vecs[16];
  int   c1, c2, c3;
  exp_t e0;

  initial begin
    vecs[0]  = '{3'd4, 6'b011111, 6'b000001, 6'b100000, 1'b0, 1'b0, 1'b1}; // 31+1
    vecs[1]  = '{3'd6, 6'b000101, 6'b000101, 6'b000000, 1'b1, 1'b1, 1'b0}; // 5-5
    vecs[2]  = '{3'd3, 6'b111010, 6'b000000, 6'b111101, 1'b0, 1'b0, 1'b0}; // -6>>>1
    vecs[3]  = '{3'd5, 6'b111101, 6'b000111, 6'b101011, 1'b0, 1'b1, 1'b0}; // -3*7
    vecs[4]  = '{3'd5, 6'b100000, 6'b100000, 6'b000000, 1'b1, 1'b1, 1'b1}; // -32*-32
    vecs[5]  = '{3'd7, 6'b000111, 6'b000000, 6'b100011, 1'b0, 1'b0, 1'b1}; // 7*5
    vecs[6]  = '{3'd3, 6'b100000, 6'b000000, 6'b110000, 1'b0, 1'b1, 1'b0}; // -32>>>1
    vecs[7]  = '{3'd0, 6'b101010, 6'b010101, 6'b111111, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'd1, 6'b101010, 6'b111100, 6'b101000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'd2, 6'b000001, 6'b000010, 6'b000011, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'd5, 6'b011111, 6'b011111, 6'b000001, 1'b0, 1'b0, 1'b1}; // 31*31=961
    vecs[11] = '{3'd5, 6'b100000, 6'b000001, 6'b100000, 1'b0, 1'b0, 1'b0}; // -32*1
    vecs[12] = '{3'd4, 6'b100000, 6'b111111, 6'b011111, 1'b0, 1'b0, 1'b1}; // -32+-1
    vecs[13] = '{3'd6, 6'b100000, 6'b000001, 6'b011111, 1'b0, 1'b0, 1'b1}; // -32-1
    vecs[14] = '{3'd7, 6'b111010, 6'b000000, 6'b100010, 1'b0, 1'b1, 1'b0}; // -6*5
    vecs[15] = '{3'd5, 6'b000000, 6'b100000, 6'b000000, 1'b1, 1'b1, 1'b0}; // 0*-32

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 3'd0; a = '0; b = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags", 32'({zf, pf, of}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].sel, vecs[i].a, vecs[i].b, vexp(vecs[i]), c1);
    end
    drain();

    // Single-cycle latency for ADD.
    send(3'd4, 6'b011111, 6'b000001, vexp(vecs[0]), c1);
    @(negedge clk);
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Multiply latency: busy through edges k..k+5, valid after edge k+6.
    send(3'd5, 6'b111101, 6'b000111, vexp(vecs[3]), c1);
    for (int j = 0; j < W; j++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
      chk("mul_busy_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back accepts with no bubble.
    send(3'd7, 6'b000111, 6'b000000, vexp(vecs[5]), c1);
    send(3'd4, 6'b000001, 6'b000010, model(3'd4, 6'b000001, 6'b000010), c2);
    send(3'd5, 6'b000011, 6'b111110, model(3'd5, 6'b000011, 6'b111110), c3);
    chk("b2b_accept_1", 32'(c2), 32'(c1 + 1));
    chk("b2b_accept_2", 32'(c3), 32'(c2 + 1));
    drain();

    // Backpressure: result held, new request ignored.
    out_ready = 1'b0;
    send(3'd4, 6'b011111, 6'b000001, vexp(vecs[0]), c1);
    sel = 3'd4; a = 6'b000001; b = 6'b000001; in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_y", 32'(y), 32'b100000);
      chk("bp_of", 32'(of), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset while a result is pending.
    out_ready = 1'b0;
    send(3'd4, 6'b011111, 6'b000001, vexp(vecs[0]), c1);
    #2;
    rst_n = 1'b0;
    #1;
    void'(q.pop_back());
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_y", 32'(y), 32'd0);
    chk("async_rst_flags", 32'({zf, pf, of}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);

    // Reset during MUL_RUN discards the operation.
    send(3'd5, 6'b000011, 6'b000011, model(3'd5, 6'b000011, 6'b000011), c1);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("no_result_after_rst", 32'(out_valid), 32'd0);
    end
    send(3'd5, 6'b111101, 6'b000111, vexp(vecs[3]), c1);
    drain();

    // Random operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [2:0]   rs;
      logic [W-1:0] ra, rb;
      rs = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      send(rs, ra, rb, model(rs, ra, rb), c1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
